dco_shift_divider: RTL
======================

// Module: dco_shift_divider
// PURPOSE
//  Digitally controlled oscillator stage of the all-digital PLL; sits directly downstream of the loop filter.
//  Divides clk_i by DIV_N to produce the recovered clock recClk_o.
//  Each positiveShift_i pulse removes one clk_i cycle from a later output period (phase advance).
//  Each negativeShift_i pulse adds one clk_i cycle (phase retard).
//  recClk_o is fed back to the phase detector as its local signal.
// PARAMETERS
//  DIV_N        100  nominal clk_i cycles per output period; even, >= 4
//  MAX_PENDING  7    saturation magnitude of the signed pending-correction accumulator
//  CNT_W        $clog2(DIV_N+1)            period counter width (derived)
//  PEND_W       $clog2(MAX_PENDING+1)+1    signed accumulator width (derived)
// PORTS
//  clk_i            in   1       system clock; single clock domain
//  reset_i          in   1       synchronous, active-high reset
//  enable_i         in   1       run oscillator; low = hold output low
//  positiveShift_i  in   1       one-cycle pulse from loop filter: advance phase by 1 clk_i
//  negativeShift_i  in   1       one-cycle pulse from loop filter: retard phase by 1 clk_i
//  recClk_o         out  1       recovered clock, registered
//  edge_o           out  1       one-cycle pulse coinciding with each recClk_o rising edge
//  pending_o        out  PEND_W  signed pending corrections not yet applied
//  saturated_o      out  1       one-cycle pulse when a shift request is dropped at saturation
// BEHAVIOUR
//  Reset (reset_i=1 at a clk_i edge):
//   - state=IDLE, cnt=0, term=DIV_N-1.
//   - recClk_o=0, edge_o=0, pending_o=0, saturated_o=0.
//   - reset_i overrides all other inputs; mid-period reset discards pending corrections.
//  FSM states:
//   - IDLE: cnt held 0, recClk_o=0, edge_o=0. Goes to RUN on the edge where enable_i=1.
//   - RUN: goes back to IDLE on the edge where enable_i=0; cnt cleared, pending kept.
//  Latency: the first RUN cycle (1 clk_i after enable_i rises) has cnt=0, recClk_o=1, edge_o=1.
//  Period counter (RUN):
//   - cnt increments each cycle; at cnt==term it wraps to 0.
//   - At the wrap, term for the new period is chosen from pending_q (value before this cycle's update):
//     - pending_q>0: term=DIV_N-2, corr=+1 (99-cycle period)
//     - pending_q<0: term=DIV_N, corr=-1 (101-cycle period)
//     - pending_q==0: term=DIV_N-1, corr=0
//   - corr is 0 on non-wrap cycles and in IDLE.
//   - At most one correction is applied per output period.
//  Output decode:
//   - recClk_o is a flop = (next cnt < DIV_N/2) in RUN.
//   - High phase is always DIV_N/2 cycles; corrections change only the low phase.
//   - edge_o is a flop = 1 when next cnt==0 in RUN.
//  Accumulator:
//   - raw = pending_q + positiveShift_i - negativeShift_i - corr (PEND_W+1 bits).
//   - Clamp raw to [-MAX_PENDING, +MAX_PENDING].
//   - saturated_o=1 on the next cycle iff clamping changed the value.
//   - Both shift inputs high in the same cycle cancel; pending is unchanged except for corr.
//   - A shift arriving on a wrap cycle is accumulated; it does not affect that wrap's term choice.
//   - Shifts are accumulated in IDLE as well.
// TESTING (DIV_N=100, MAX_PENDING=7)
//  1. Reset, enable_i=1, no shifts:
//     edge_o every 100 cycles; recClk_o 50 high / 50 low; pending_o=0.
//  2. One positiveShift_i pulse at cnt=30:
//     pending_o=1; next period is 99 cycles (49 low); following periods are 100; pending_o back to 0.
//  3. One negativeShift_i pulse at cnt=30:
//     pending_o=-1; next period is 101 cycles (51 low); then 100.
//  4. Ten consecutive positiveShift_i pulses:
//     pending_o saturates at 7; saturated_o pulses 3 times; next 7 periods are 99; then 100.
//  5. positiveShift_i=negativeShift_i=1 for 5 cycles:
//     pending_o stays 0; all periods are 100; saturated_o stays 0.
//  6. Reset asserted mid-period with pending_o=3:
//     next cycle all outputs are 0; after enable, first period is 100.
//     Also: enable_i low mid-period gives recClk_o=0 on the next cycle with pending kept.

Source files
------------

// File: rtl/dco_shift_divider.sv
// Digitally controlled oscillator for the all-digital PLL: divides clk_i by DIV_N
// and slips/stretches single clk_i cycles on request from the loop filter.
module dco_shift_divider #(
  parameter int DIV_N       = 100,
  parameter int MAX_PENDING = 7,
  parameter int CNT_W       = $clog2(DIV_N + 1),
  parameter int PEND_W      = $clog2(MAX_PENDING + 1) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              positiveShift_i,
  input  logic              negativeShift_i,
  output logic              recClk_o,
  output logic              edge_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              saturated_o
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam logic [CNT_W-1:0] TERM_NOM   = CNT_W'(DIV_N - 1);
  localparam logic [CNT_W-1:0] TERM_SHORT = CNT_W'(DIV_N - 2);
  localparam logic [CNT_W-1:0] TERM_LONG  = CNT_W'(DIV_N);
  localparam logic [CNT_W-1:0] HALF       = CNT_W'(DIV_N / 2);

  localparam logic signed [PEND_W:0] RAW_MAX = (PEND_W + 1)'(MAX_PENDING);
  localparam logic signed [PEND_W:0] RAW_MIN = -RAW_MAX;

  logic                     state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         term_q, term_d;
  logic signed [PEND_W-1:0] pending_q, pending_d;
  logic                     rec_d, edge_d, sat_d;
  logic                     corr_up, corr_dn;
  logic                     pend_pos, pend_neg;
  logic signed [PEND_W:0]   raw;

  function automatic logic signed [PEND_W-1:0] clamp_pend(input logic signed [PEND_W:0] val);
    if (val > RAW_MAX)      return RAW_MAX[PEND_W-1:0];
    else if (val < RAW_MIN) return RAW_MIN[PEND_W-1:0];
    else                    return val[PEND_W-1:0];
  endfunction

  assign pend_neg = pending_q[PEND_W-1];
  assign pend_pos = !pending_q[PEND_W-1] && (pending_q != '0);

  // Next-state decode: counter, per-period terminal count and output flops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    rec_d   = 1'b0;
    edge_d  = 1'b0;
    corr_up = 1'b0;
    corr_dn = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) begin
          state_d = RUN;
          rec_d   = 1'b1;
          edge_d  = 1'b1;
        end
      end
      default: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q == term_q) begin
            // Only one correction per period: term is picked once, at the wrap
            cnt_d = '0;
            if (pend_pos) begin
              term_d  = TERM_SHORT;
              corr_up = 1'b1;
            end else if (pend_neg) begin
              term_d  = TERM_LONG;
              corr_dn = 1'b1;
            end else begin
              term_d  = TERM_NOM;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          rec_d  = (cnt_d < HALF);
          edge_d = (cnt_d == '0);
        end
      end
    endcase
  end

  // Pending-correction accumulator with symmetric saturation
  always_comb begin
    raw = {pending_q[PEND_W-1], pending_q}
        + $signed({{PEND_W{1'b0}}, positiveShift_i})
        - $signed({{PEND_W{1'b0}}, negativeShift_i})
        - $signed({{PEND_W{1'b0}}, corr_up})
        + $signed({{PEND_W{1'b0}}, corr_dn});
    pending_d = clamp_pend(raw);
    sat_d     = ({pending_d[PEND_W-1], pending_d} != raw);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      term_q      <= TERM_NOM;
      pending_q   <= '0;
      recClk_o    <= 1'b0;
      edge_o      <= 1'b0;
      saturated_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      term_q      <= term_d;
      pending_q   <= pending_d;
      recClk_o    <= rec_d;
      edge_o      <= edge_d;
      saturated_o <= sat_d;
    end
  end

  assign pending_o = pending_q;

endmodule
